tile_fetch_arbiter: RTL and testbench

TILE_FETCH_ARBITER -- requirements
Module: tile_fetch_arbiter

---
 rtl/tile_fetch_arbiter_if.sv | 28 ++
 rtl/tile_fetch_arbiter.sv | 166 ++++++++++++++++
 tb/tb_tile_fetch_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_fetch_arbiter_if.sv
// Game-logic request port and board RAM port of the tile fetch arbiter.
// The slave modport is the arbiter; the master modport is the game logic plus RAM side.
interface tile_fetch_arbiter_if;
    localparam int unsigned AW = 10;
    localparam int unsigned TW = 3;

    logic          gl_req;
    logic          gl_we;
    logic [AW-1:0] gl_addr;
    logic [TW-1:0] gl_wdata;
    logic          gl_ack;
    logic [TW-1:0] gl_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [TW-1:0] mem_wdata;
    logic [TW-1:0] mem_rdata;

    modport slave (
        input  gl_req, gl_we, gl_addr, gl_wdata, mem_rdata,
        output gl_ack, gl_rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output gl_req, gl_we, gl_addr, gl_wdata, mem_rdata,
        input  gl_ack, gl_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/tile_fetch_arbiter.sv
// Shares one board RAM port between the tile renderer (3-stage pipeline, absolute
// priority, one-entry tile cache) and game-logic read/write requests.
module tile_fetch_arbiter #(
    parameter int unsigned TILE   = 20,
    parameter int unsigned COLS   = 32,
    parameter int unsigned ROWS   = 24,
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [9:0]            x,
    input  logic [8:0]            y,
    tile_fetch_arbiter_if.slave   bus,
    output logic [2:0]            tile_type,
    output logic [4:0]            local_x,
    output logic [4:0]            local_y,
    output logic                  tile_valid
);
    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 9;
    localparam int unsigned AW    = 10;
    localparam int unsigned TW    = 3;
    localparam int unsigned LW    = 5;
    localparam int unsigned BXW   = 6;
    localparam int unsigned BYW   = 5;
    localparam int unsigned BOARD = ROWS * COLS;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    state_e        state_q, state_d;
    logic [BXW-1:0] bx_c;
    logic [BYW-1:0] by_c;
    logic [LW-1:0] lx_d, ly_d, lx_q, ly_q, lx2_q, ly2_q;
    logic [AW-1:0] idx_d, idx_q;
    logic          on_d, on_q, on2_q, pend_q;
    logic          need_c, grant_c;
    logic          cache_valid_q, cache_valid_d;
    logic [AW-1:0] cached_idx_q, cached_idx_d;
    logic [TW-1:0] hold_q, hold_d, tile_type_q, tile_type_d;
    logic [LW-1:0] local_x_q, local_y_q;
    logic          tile_valid_q;
    logic [AW-1:0] mem_addr_q, mem_addr_c;
    logic          mem_we_c;
    logic [AW-1:0] addr_q, addr_d;
    logic [TW-1:0] gl_rdata_q, gl_rdata_d;
    logic          gl_ack_q, gl_ack_d;

    // Stage 1 address decode: board cell, position inside the cell, visibility.
    always_comb begin
        bx_c  = BXW'(x / XW'(TILE));
        by_c  = BYW'(y / YW'(TILE));
        lx_d  = LW'(x % XW'(TILE));
        ly_d  = LW'(y % YW'(TILE));
        idx_d = AW'(32'(by_c) * COLS + 32'(bx_c));
        on_d  = (x < XW'(WIDTH)) && (y < YW'(HEIGHT));
    end

    assign need_c = on_q && (!cache_valid_q || (idx_q != cached_idx_q));

    // Game FSM and RAM port mux; the renderer's fetch always wins the port.
    always_comb begin
        state_d    = state_q;
        grant_c    = 1'b0;
        addr_d     = addr_q;
        gl_rdata_d = gl_rdata_q;
        mem_addr_c = mem_addr_q;
        mem_we_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.gl_req && !need_c && !reset) begin
                    grant_c = 1'b1;
                    addr_d  = bus.gl_addr;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                gl_rdata_d = (addr_q < AW'(BOARD)) ? bus.mem_rdata : '0;
                state_d    = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (need_c) begin
            mem_addr_c = idx_q;
        end else if (grant_c) begin
            mem_addr_c = bus.gl_addr;
            mem_we_c   = bus.gl_we && (bus.gl_addr < AW'(BOARD));
        end
        gl_ack_d = (state_d == ACK);
    end

    // Tile cache update; a game write to the cached cell forces a refetch.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cached_idx_d  = cached_idx_q;
        if (need_c) begin
            cache_valid_d = 1'b1;
            cached_idx_d  = idx_q;
        end else if (grant_c && bus.gl_we && (bus.gl_addr == cached_idx_q)) begin
            cache_valid_d = 1'b0;
        end
    end

    // Stage 3 tile type: fresh RAM data on a fetch, otherwise the last fetched type.
    always_comb begin
        hold_d      = pend_q ? bus.mem_rdata : hold_q;
        tile_type_d = on2_q ? hold_d : '0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lx_q          <= '0;
            ly_q          <= '0;
            idx_q         <= '0;
            on_q          <= 1'b0;
            pend_q        <= 1'b0;
            lx2_q         <= '0;
            ly2_q         <= '0;
            on2_q         <= 1'b0;
            cache_valid_q <= 1'b0;
            cached_idx_q  <= '0;
            hold_q        <= '0;
            tile_type_q   <= '0;
            local_x_q     <= '0;
            local_y_q     <= '0;
            tile_valid_q  <= 1'b0;
            mem_addr_q    <= '0;
            addr_q        <= '0;
            gl_rdata_q    <= '0;
            gl_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            lx_q          <= lx_d;
            ly_q          <= ly_d;
            idx_q         <= idx_d;
            on_q          <= on_d;
            pend_q        <= need_c;
            lx2_q         <= lx_q;
            ly2_q         <= ly_q;
            on2_q         <= on_q;
            cache_valid_q <= cache_valid_d;
            cached_idx_q  <= cached_idx_d;
            hold_q        <= hold_d;
            tile_type_q   <= tile_type_d;
            local_x_q     <= lx2_q;
            local_y_q     <= ly2_q;
            tile_valid_q  <= on2_q;
            mem_addr_q    <= mem_addr_c;
            addr_q        <= addr_d;
            gl_rdata_q    <= gl_rdata_d;
            gl_ack_q      <= gl_ack_d;
        end
    end

    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_wdata = bus.gl_wdata;
    assign bus.gl_ack    = gl_ack_q;
    assign bus.gl_rdata  = gl_rdata_q;
    assign tile_type     = tile_type_q;
    assign local_x       = local_x_q;
    assign local_y       = local_y_q;
    assign tile_valid    = tile_valid_q;
endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// Directed bench for tile_fetch_arbiter: board RAM model with 1-cycle read,
// scan vectors with hand-derived tile contents, and game-port transactions.
module tb_tile_fetch_arbiter;
    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] tile_type;
    logic [4:0] local_x;
    logic [4:0] local_y;
    logic       tile_valid;

    tile_fetch_arbiter_if bus ();

    tile_fetch_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .bus        (bus),
        .tile_type  (tile_type),
        .local_x    (local_x),
        .local_y    (local_y),
        .tile_valid (tile_valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int vectors     = 0;
    int miscompares = 0;

    // Board RAM: synchronous write, registered read; bench backdoor has priority.
    logic [2:0] ram [0:1023];
    logic [2:0] exp_board [0:1023];
    logic [2:0] rd_q;
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr = '0;
    logic [2:0] bd_data = '0;
    int         bad_we = 0;

    always @(posedge CLOCK_50) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rd_q <= ram[bus.mem_addr];
        if (bus.mem_we && bus.mem_addr >= 10'd768) bad_we <= bad_we + 1;
    end
    assign bus.mem_rdata = rd_q;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic bd_write(input int addr, input logic [2:0] data);
        bd_addr = 10'(addr);
        bd_data = data;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    // Apply n pixels on row yv; each result is checked 3 edges after its pixel.
    task automatic scan(input int yv, input int x0, input int n, input string tag);
        int         px;
        logic       on;
        logic [2:0] et;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                x = 10'(x0 + i);
                y = 9'(yv);
            end
            tick();
            if (i >= 2) begin
                px = x0 + i - 2;
                on = (px < 640) && (yv < 480);
                et = on ? exp_board[(yv / 20) * 32 + px / 20] : 3'd0;
                vectors++;
                if (tile_type !== et) begin
                    miscompares++;
                    $display("FAIL %s tile_type x=%0d y=%0d: got %0d want %0d", tag, px, yv, tile_type, et);
                end
                vectors++;
                if (tile_valid !== on) begin
                    miscompares++;
                    $display("FAIL %s tile_valid x=%0d y=%0d: got %0b want %0b", tag, px, yv, tile_valid, on);
                end
                vectors++;
                if (local_x !== 5'(px % 20)) begin
                    miscompares++;
                    $display("FAIL %s local_x x=%0d: got %0d want %0d", tag, px, local_x, px % 20);
                end
                vectors++;
                if (local_y !== 5'(yv % 20)) begin
                    miscompares++;
                    $display("FAIL %s local_y y=%0d: got %0d want %0d", tag, yv, local_y, yv % 20);
                end
            end
        end
    endtask

    // One game transaction; cycle 1 is the cycle gl_req is first presented.
    task automatic game(input logic we, input int addr, input logic [2:0] wd, input int delay,
                        input int exp_cyc, input logic [2:0] exp_rd, input string tag);
        int cyc;
        bit got;
        repeat (delay) tick();
        bus.gl_req   = 1'b1;
        bus.gl_we    = we;
        bus.gl_addr  = 10'(addr);
        bus.gl_wdata = wd;
        cyc = 0;
        got = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            if (bus.gl_ack === 1'b1) begin
                got = 1'b1;
                cyc = c;
            end else begin
                tick();
            end
        end
        vectors++;
        if (cyc != exp_cyc) begin
            miscompares++;
            $display("FAIL %s ack cycle: got %0d want %0d (0 = no ack)", tag, cyc, exp_cyc);
        end
        if (got && !we) begin
            vectors++;
            if (bus.gl_rdata !== exp_rd) begin
                miscompares++;
                $display("FAIL %s gl_rdata: got %0d want %0d", tag, bus.gl_rdata, exp_rd);
            end
        end
        bus.gl_req = 1'b0;
        tick();
        vectors++;
        if (bus.gl_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ack width: got %0b want 0 one cycle later", tag, bus.gl_ack);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        x            = 10'd5;
        y            = 9'd5;
        bus.gl_req   = 1'b1;
        bus.gl_we    = 1'b1;
        bus.gl_addr  = 10'd3;
        bus.gl_wdata = 3'd1;
        bd_write(0, 3'd2);
        bd_write(1, 3'd5);
        tick();
        vectors++;
        if ({bus.gl_ack, bus.gl_rdata, bus.mem_we, bus.mem_addr} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got ack=%0b rdata=%0d we=%0b addr=%0d want all 0",
                     bus.gl_ack, bus.gl_rdata, bus.mem_we, bus.mem_addr);
        end
        vectors++;
        if ({tile_type, local_x, local_y, tile_valid} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_video: got type=%0d lx=%0d ly=%0d valid=%0b want all 0",
                     tile_type, local_x, local_y, tile_valid);
        end
        bus.gl_req = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic test_scan_two_tiles();
        scan(0, 0, 40, "scan_two_tiles");
    endtask

    // Tile 1 is cached: a backdoor change to RAM[1] must not be seen.
    task automatic test_cache_hit();
        bd_write(1, 3'd6);
        scan(0, 25, 8, "cache_hit");
        bd_write(1, 3'd5);
    endtask

    task automatic test_game_write_in_tile();
        fork
            scan(0, 0, 15, "write_in_tile_video");
            game(1'b1, 33, 3'd4, 6, 3, 3'd0, "write_in_tile");
        join
        vectors++;
        if (ram[33] !== 3'd4) begin
            miscompares++;
            $display("FAIL ram33: got %0d want 4", ram[33]);
        end
    endtask

    task automatic test_grant_slip();
        fork
            scan(0, 15, 12, "slip_video");
            game(1'b0, 33, 3'd0, 6, 4, 3'd4, "slip");
        join
    endtask

    task automatic test_coherence();
        bd_write(5, 3'd3);
        exp_board[5] = 3'd3;
        scan(0, 100, 5, "coh_before");
        game(1'b1, 5, 3'd7, 0, 3, 3'd0, "coh_write");
        exp_board[5] = 3'd7;
        vectors++;
        if (tile_type !== 3'd7) begin
            miscompares++;
            $display("FAIL coh_refetch: got %0d want 7", tile_type);
        end
        scan(0, 105, 6, "coh_after");
    endtask

    task automatic test_out_of_range();
        logic [9:0] a0;
        game(1'b0, 800, 3'd0, 0, 3, 3'd0, "oor_read");
        game(1'b1, 800, 3'd5, 0, 3, 3'd0, "oor_write");
        vectors++;
        if (bad_we !== 0) begin
            miscompares++;
            $display("FAIL oor_we: got %0d out-of-range writes want 0", bad_we);
        end
        a0 = bus.mem_addr;
        scan(0, 640, 6, "offscreen_x");
        scan(480, 0, 3, "offscreen_y");
        vectors++;
        if (bus.mem_addr !== a0) begin
            miscompares++;
            $display("FAIL offscreen_fetch: mem_addr got %0d want %0d", bus.mem_addr, a0);
        end
    endtask

    task automatic test_back_to_back();
        logic ea;
        bus.gl_req  = 1'b1;
        bus.gl_we   = 1'b0;
        bus.gl_addr = 10'd33;
        for (int c = 1; c <= 7; c++) begin
            ea = (c == 3) || (c == 6);
            vectors++;
            if (bus.gl_ack !== ea) begin
                miscompares++;
                $display("FAIL b2b ack cycle %0d: got %0b want %0b", c, bus.gl_ack, ea);
            end
            if (ea) begin
                vectors++;
                if (bus.gl_rdata !== 3'd4) begin
                    miscompares++;
                    $display("FAIL b2b rdata cycle %0d: got %0d want 4", c, bus.gl_rdata);
                end
            end
            if (c == 6) bus.gl_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_in_wait();
        scan(5, 3, 3, "rst_prime");
        bd_write(0, 3'd6);
        exp_board[0] = 3'd6;
        bus.gl_req  = 1'b1;
        bus.gl_we   = 1'b0;
        bus.gl_addr = 10'd33;
        tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({bus.gl_ack, bus.gl_rdata, bus.mem_we, bus.mem_addr} !== 15'd0) begin
            miscompares++;
            $display("FAIL rst_wait_bus: got ack=%0b rdata=%0d we=%0b addr=%0d want all 0",
                     bus.gl_ack, bus.gl_rdata, bus.mem_we, bus.mem_addr);
        end
        vectors++;
        if ({tile_type, local_x, local_y, tile_valid} !== 14'd0) begin
            miscompares++;
            $display("FAIL rst_wait_video: got type=%0d lx=%0d ly=%0d valid=%0b want all 0",
                     tile_type, local_x, local_y, tile_valid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (bus.gl_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_hold cycle %0d: got ack=%0b we=%0b want 0 0", c, bus.gl_ack, bus.mem_we);
            end
        end
        bus.gl_req = 1'b0;
        reset      = 1'b0;
        scan(5, 5, 4, "rst_refetch");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) exp_board[i] = 3'd0;
        exp_board[0] = 3'd2;
        exp_board[1] = 3'd5;
        test_reset();
        test_scan_two_tiles();
        test_cache_hit();
        test_game_write_in_tile();
        test_grant_slip();
        test_coherence();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
